// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states and Booth digit encoding.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  // Digit encoding {neg, one, two}: magnitude select plus negate flag.
  typedef logic [2:0] digit_t;

  localparam digit_t ZERO = 3'b000;
  localparam digit_t P1   = 3'b010;
  localparam digit_t P2   = 3'b001;
  localparam digit_t M1   = 3'b110;
  localparam digit_t M2   = 3'b101;
  localparam digit_t M0   = 3'b100;  // window 111: ~0 + 1, contributes zero

  function automatic digit_t booth_sel(input logic [2:0] win);
    digit_t d;
    case (win)
      3'b000:         d = ZERO;
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = M0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// One radix-4 Booth partial product: one's-complement value plus negate (carry-in) bit.
module booth_r4_pp_gen
  import booth_pkg::*;
#(
  parameter int W = 18
) (
  input  logic [2:0] win_i,
  input  logic [W-1:0] a_i,
  output logic [W:0]   pp_o,
  output logic         neg_o
);

  digit_t     dig;
  logic [W:0] mag;

  always_comb begin
    dig = booth_sel(win_i);
    mag = '0;
    if (dig[1])      mag = {a_i[W-1], a_i};
    else if (dig[0]) mag = {a_i, 1'b0};
    pp_o  = dig[2] ? ~mag : mag;
    neg_o = dig[2];
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock, valid/ready on both sides.
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int NDIG = WIDTH/2 + 1;
  localparam int EW   = WIDTH + 2;
  localparam int AW   = 2*WIDTH + 4;
  localparam int CW   = $clog2(NDIG);

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic            mode_q, mode_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            accept;
  logic            last_dig;
  logic [EW-1:0]   a_ext;
  logic [EW:0]     b_src, b_sh;
  logic [2:0]      win;
  logic [EW:0]     pp;
  logic            neg;
  logic [AW-1:0]   pp_sh, cin_sh, acc_sum;
  logic [CW:0]     shamt;

  assign accept   = (state_q == IDLE) && in_valid;
  assign last_dig = (cnt_q == CW'(NDIG-1));
  assign shamt    = {cnt_q, 1'b0};

  // Extension is derived from the latched mode, so later changes on signed_mode are invisible.
  assign a_ext = {{2{mode_q & a_q[WIDTH-1]}}, a_q};
  assign b_src = {{2{mode_q & b_q[WIDTH-1]}}, b_q, 1'b0};
  assign b_sh  = b_src >> shamt;
  assign win   = b_sh[2:0];

  booth_r4_pp_gen #(.W(EW)) u_pp (
    .win_i (win),
    .a_i   (a_ext),
    .pp_o  (pp),
    .neg_o (neg)
  );

  assign pp_sh   = {{(AW-EW-1){pp[EW]}}, pp} << shamt;
  assign cin_sh  = {{(AW-1){1'b0}}, neg} << shamt;
  assign acc_sum = acc_q + pp_sh + cin_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = CALC;
      CALC:    if (last_dig)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    mode_d = mode_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    if (accept) begin
      a_d    = a;
      b_d    = b;
      mode_d = signed_mode;
      acc_d  = '0;
      cnt_d  = '0;
    end else if (state_q == CALC) begin
      acc_d = acc_sum;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      mode_q <= mode_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
    end
  end

  assign product = acc_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Self-checking bench for booth_r4_seq_mult: vector table, directed corner cases, random scoreboard run.
module tb_booth_r4_seq_mult;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, signed_mode;
  logic [15:0] a, b;
  logic [31:0] product;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  bit          mon_en = 0, rnd_ready = 0, dir_ready = 1, rr = 1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        m;
    logic [31:0] p;
  } vec_t;
  vec_t vt[10];

  assign out_ready = rnd_ready ? rr : dir_ready;

  booth_r4_seq_mult #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y, input logic m);
    int s;
    if (m) begin
      s = int'($signed(x)) * int'($signed(y));
      return s;
    end
    return {16'd0, x} * {16'd0, y};
  endfunction

  // Transfer occurs at the next posedge when out_valid && ready are both seen here.
  always @(negedge clk) begin
    if (mon_en) begin
      bit rdy;
      rr  = ($urandom_range(0, 99) < 70);
      rdy = rnd_ready ? rr : dir_ready;
      if (out_valid && rdy) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_result: got 0x%0h expected none", product);
        end else begin
          chk("product", product, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic m,
                      input bit push, input logic [31:0] ev);
    int n = 0;
    @(negedge clk);
    a = av; b = bv; signed_mode = m; in_valid = 1;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
      in_valid = 0;
      return;
    end
    if (push) exp_q.push_back(ev);
    @(posedge clk); #1;
    in_valid = 0;
    a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    int c;
    logic [31:0] e;
    logic [15:0] ra, rb;
    logic rm;

    vt[0] = '{16'd3,    16'd5,    1'b0, 32'h0000000F};
    vt[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vt[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
    vt[3] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
    vt[4] = '{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000};
    vt[5] = '{16'h8000, 16'h8000, 1'b0, 32'h40000000};
    vt[6] = '{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000};
    vt[7] = '{16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE};
    vt[8] = '{16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE};
    vt[9] = '{16'h0000, 16'hABCD, 1'b1, 32'h00000000};

    rst_n = 0; in_valid = 0; a = 0; b = 0; signed_mode = 0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    @(negedge clk); rst_n = 1; mon_en = 1;

    for (int i = 0; i < 10; i++) begin
      send(vt[i].a, vt[i].b, vt[i].m, 1, vt[i].p);
      if (i == 0) begin
        c = 1;
        while (!out_valid && c < 50) begin @(posedge clk); #1; c++; end
        chk("latency_cycle", c, 10);
      end
      wait_drain(50);
    end

    // Consumer stalls in DONE while the producer keeps offering operands.
    dir_ready = 0;
    e = model(16'h1234, 16'h5678, 1'b0);
    send(16'h1234, 16'h5678, 1'b0, 1, e);
    c = 0;
    while (!out_valid && c < 30) begin @(negedge clk); c++; end
    chk("hold_reach_done", out_valid, 1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid = k[0]; a = 16'($urandom); b = 16'($urandom);
      chk("hold_product", product, e);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    in_valid = 0; dir_ready = 1;
    wait_drain(10);
    repeat (15) @(negedge clk);
    chk("no_second_accept_valid", out_valid, 0);
    chk("no_second_accept_ready", in_ready, 1);

    // Reset in the middle of CALC discards the partial result.
    send(16'h4321, 16'h0BCD, 1'b1, 0, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_product", product, 0);
    @(negedge clk); rst_n = 1;
    send(16'd7, 16'd9, 1'b0, 1, 32'd63);
    wait_drain(50);

    rnd_ready = 1;
    for (int k = 0; k < 3000; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom);
      if (k % 50 == 0) ra = 16'h8000;
      send(ra, rb, rm, 1, model(ra, rb, rm));
    end
    wait_drain(400);
    repeat (20) @(negedge clk);
    chk("final_idle", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
